// File: rtl/riscv_alu_unit.sv
// RV32I execute-stage ALU: shifts, add/sub, logic ops and compares, with a registered result.
// Optional registered zero flag (alu_zero_o) when RISCV_ALU_FLAGS_EN is defined.
module riscv_alu_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] alu_a_i,
  input  logic [31:0] alu_b_i,
  output logic [31:0] alu_p_o
`ifdef RISCV_ALU_FLAGS_EN
  ,
  output logic        alu_zero_o
`endif
);

  typedef enum logic [3:0] {
    ALU_NONE         = 4'b0000,
    ALU_SHIFTL       = 4'b0001,
    ALU_SHIFTR       = 4'b0010,
    ALU_SHIFTR_ARITH = 4'b0011,
    ALU_ADD          = 4'b0100,
    ALU_SUB          = 4'b0110,
    ALU_AND          = 4'b0111,
    ALU_OR           = 4'b1000,
    ALU_XOR          = 4'b1001,
    ALU_LESS_THAN    = 4'b1010,
    ALU_LESS_THAN_S  = 4'b1011
  } alu_op_e;

  alu_op_e     op;
  logic [4:0]  shamt;
  logic [32:0] diff;
  logic        borrow;
  logic        lt_signed;
  logic [31:0] alu_p_d;
  logic [31:0] alu_p_q;

  assign op     = alu_op_e'(alu_op_i);
  assign shamt  = alu_b_i[4:0];

  // SUB and both compares share this one 33-bit subtractor; bit 32 is the borrow.
  assign diff      = {1'b0, alu_a_i} - {1'b0, alu_b_i};
  assign borrow    = diff[32];
  assign lt_signed = (alu_a_i[31] != alu_b_i[31]) ? alu_a_i[31] : borrow;

  always_comb begin
    // NOTE: default assigned first so no path leaves alu_p_d unassigned (no latch).
    alu_p_d = alu_a_i;
    unique case (op)
      ALU_SHIFTL:       alu_p_d = alu_a_i << shamt;
      ALU_SHIFTR:       alu_p_d = alu_a_i >> shamt;
      ALU_SHIFTR_ARITH: alu_p_d = $unsigned($signed(alu_a_i) >>> shamt);
      ALU_ADD:          alu_p_d = alu_a_i + alu_b_i;
      ALU_SUB:          alu_p_d = diff[31:0];
      ALU_AND:          alu_p_d = alu_a_i & alu_b_i;
      ALU_OR:           alu_p_d = alu_a_i | alu_b_i;
      ALU_XOR:          alu_p_d = alu_a_i ^ alu_b_i;
      ALU_LESS_THAN:    alu_p_d = {31'd0, borrow};
      ALU_LESS_THAN_S:  alu_p_d = {31'd0, lt_signed};
      default:          alu_p_d = alu_a_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) alu_p_q <= 32'h0;
    else       alu_p_q <= alu_p_d;
  end

  assign alu_p_o = alu_p_q;

`ifdef RISCV_ALU_FLAGS_EN
  logic alu_zero_q;

  // Flag is computed from the next result so it lands in the same cycle as alu_p_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) alu_zero_q <= 1'b1;
    else       alu_zero_q <= (alu_p_d == 32'h0);
  end

  assign alu_zero_o = alu_zero_q;
`endif

endmodule

// File: tb/tb_riscv_alu_unit.sv
// Self-checking bench for riscv_alu_unit: directed corner cases plus a randomized
// pipelined sweep of all 16 opcodes against an arithmetic reference model.
module tb_riscv_alu_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  alu_op_i;
  logic [31:0] alu_a_i;
  logic [31:0] alu_b_i;
  logic [31:0] alu_p_o;
`ifdef RISCV_ALU_FLAGS_EN
  logic        alu_zero_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  riscv_alu_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .alu_op_i (alu_op_i),
    .alu_a_i  (alu_a_i),
    .alu_b_i  (alu_b_i),
    .alu_p_o  (alu_p_o)
`ifdef RISCV_ALU_FLAGS_EN
    ,
    .alu_zero_o (alu_zero_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written directly from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd1:    return a << sh;
      4'd2:    return a >> sh;
      4'd3:    return $unsigned($signed(a) >>> sh);
      4'd4:    return a + b;
      4'd6:    return a - b;
      4'd7:    return a & b;
      4'd8:    return a | b;
      4'd9:    return a ^ b;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      4'd11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  // Drive on a falling edge, sample on the next falling edge: exactly one rising edge between.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk_i);
    alu_op_i = op;
    alu_a_i  = a;
    alu_b_i  = b;
    @(negedge clk_i);
    check(tag, alu_p_o, exp);
`ifdef RISCV_ALU_FLAGS_EN
    check({tag, "_zero"}, {31'd0, alu_zero_o}, {31'd0, exp == 32'h0});
`endif
  endtask

  logic [31:0] prev_exp;
  logic        have_prev;
  logic [31:0] ra, rb;

  initial begin
    rst_i    = 1'b1;
    alu_op_i = 4'd4;
    alu_a_i  = 32'h1234_5678;
    alu_b_i  = 32'h0000_0011;
    #2;
    check("reset_immediate", alu_p_o, 32'h0);
    repeat (2) @(negedge clk_i);
    check("reset_held", alu_p_o, 32'h0);
`ifdef RISCV_ALU_FLAGS_EN
    check("reset_zero", {31'd0, alu_zero_o}, 32'd1);
`endif
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_release_add", alu_p_o, 32'h1234_5689);

    // Reset mid-stream: asynchronous clear, pending result discarded.
    apply("pre_reset_or", 4'd8, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 check("midstream_reset_async", alu_p_o, 32'h0);
    @(negedge clk_i);
    check("midstream_reset_held", alu_p_o, 32'h0);
    alu_op_i = 4'd6;
    alu_a_i  = 32'd100;
    alu_b_i  = 32'd58;
    rst_i    = 1'b0;
    @(negedge clk_i);
    check("after_reset_sub", alu_p_o, 32'd42);

    apply("add_wrap", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
    apply("sub_wrap", 4'd6, 32'h0, 32'h1, 32'hFFFF_FFFF);

    apply("shl4",  4'd1, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0000_0010);
    apply("shr4",  4'd2, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0800_0000);
    apply("sra4",  4'd3, 32'h8000_0001, 32'hFFFF_FFE4, 32'hF800_0000);
    apply("shl0",  4'd1, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("shr0",  4'd2, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("sra0",  4'd3, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("sra31", 4'd3, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);

    apply("sltu_neg", 4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0);
    apply("slt_neg",  4'd11, 32'hFFFF_FFFF, 32'h1, 32'h1);
    apply("sltu_eq",  4'd10, 32'd5, 32'd5, 32'h0);
    apply("slt_eq",   4'd11, 32'd5, 32'd5, 32'h0);
    apply("sltu_lt",  4'd10, 32'd4, 32'd5, 32'h1);
    apply("slt_pos",  4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);

    apply("and", 4'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    apply("or",  4'd8, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF);
    apply("xor", 4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    apply("undef_0101", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234);
    for (int op = 12; op < 16; op++)
      apply($sformatf("undef_%0d", op), 4'(op), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234);

    // Pipelined sweep: new inputs every cycle, each result checked one cycle later.
    have_prev = 1'b0;
    prev_exp  = 32'h0;
    for (int p = 0; p < 50; p++) begin
      ra = $urandom;
      rb = $urandom;
      if (p % 10 == 0) rb = ra;
      for (int op = 0; op < 16; op++) begin
        @(negedge clk_i);
        if (have_prev) begin
          check("sweep", alu_p_o, prev_exp);
`ifdef RISCV_ALU_FLAGS_EN
          check("sweep_zero", {31'd0, alu_zero_o}, {31'd0, prev_exp == 32'h0});
`endif
        end
        alu_op_i  = 4'(op);
        alu_a_i   = ra;
        alu_b_i   = rb;
        prev_exp  = ref_alu(4'(op), ra, rb);
        have_prev = 1'b1;
      end
    end
    @(negedge clk_i);
    check("sweep_last", alu_p_o, prev_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu_unit.md
Name: riscv_alu_unit

Overview:
- 32-bit integer ALU for the RV32I execute stage.
- Takes two operands and a 4-bit operation code and produces one 32-bit result.
- The result is held in an output register, so it is available one clock after the inputs are presented.
- Covers shifts, add/sub, logic ops and set-less-than (signed and unsigned).

Parameters:
- none (datapath fixed at 32 bits, opcode at 4 bits)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous reset, active-high
- alu_op_i  input  4  operation select (encodings below)
- alu_a_i  input  32  operand A (rs1 / PC)
- alu_b_i  input  32  operand B (rs2 / immediate / shift amount)
- alu_p_o  output  32  registered result

Behaviour:
- Reset: when rst_i is high, alu_p_o is forced to 32'h0 immediately, without waiting for a clock edge. It stays 0 while rst_i is high.
- Latency: result = f(alu_op_i, alu_a_i, alu_b_i) sampled at rising edge N; it appears on alu_p_o after edge N and is held until edge N+1.
- The block updates every cycle (no enable); back-to-back ops are fully pipelined at one per cycle.
- Opcode encodings and results:
  - 0000 NONE: A passes through unchanged.
  - 0001 SHIFTL: A << B[4:0], zero fill.
  - 0010 SHIFTR: A >> B[4:0], logical, zero fill.
  - 0011 SHIFTR_ARITH: A >> B[4:0], arithmetic, filled with A[31].
  - 0100 ADD: A + B modulo 2^32; carry-out discarded.
  - 0110 SUB: A - B modulo 2^32; borrow discarded.
  - 0111 AND: A & B.
  - 1000 OR: A | B.
  - 1001 XOR: A ^ B.
  - 1010 LESS_THAN: 32'd1 if A < B unsigned, else 32'd0.
  - 1011 LESS_THAN_SIGNED: 32'd1 if A < B two's complement, else 32'd0.
  - Undefined codes 0101, 1100, 1101, 1110, 1111: result = A (same as NONE).
- Shift rules: only B[4:0] is used and B[31:5] is ignored. A shift amount of 0 returns A.
- SUB and both compares share one 33-bit subtractor.
  - Unsigned: A < B when the borrow is set.
  - Signed: if A[31] != B[31], the result is A[31]; otherwise it is the borrow.
- Overflow is not flagged for any op.
- Result selection is combinational from the current inputs; the only state is the output register.
- Reset asserted mid-stream: the pending result is discarded. After rst_i is released, the first valid result is the one captured at the first rising edge after release.

Optional Feature:
- Macro: RISCV_ALU_FLAGS_EN.
- Defined:
  - Adds output alu_zero_o (1 bit, registered alongside alu_p_o).
  - alu_zero_o = 1 when the registered result is 32'h0.
  - Reset value 1, consistent with alu_p_o = 0.
- Not defined:
  - Port is absent.
  - No extra logic; all other behaviour is identical.

Test Plan:
- Reset: assert rst_i with A=32'h1234_5678, op=ADD -> alu_p_o = 0 immediately and while rst_i is held. Release rst_i -> 32'h1234_5678 + B after the next edge.
- Arithmetic wrap: ADD A=32'hFFFF_FFFF, B=1 -> 32'h0. SUB A=0, B=1 -> 32'hFFFF_FFFF. Each result appears exactly one cycle after the inputs are applied.
- Shifts with A=32'h8000_0001, B=32'hFFFF_FFE4 (B[4:0]=4):
  - SHIFTL -> 32'h0000_0010
  - SHIFTR -> 32'h0800_0000
  - SHIFTR_ARITH -> 32'hF800_0000
  - B[4:0]=0 -> A for all three shifts
- Compares, A=32'hFFFF_FFFF, B=1: LESS_THAN -> 0, LESS_THAN_SIGNED -> 1. A=5, B=5: both -> 0.
- Logic/undefined with A=32'hF0F0_1234, B=32'h0FF0_FFFF:
  - AND -> 32'h00F0_1234
  - OR -> 32'hFFF0_FFFF
  - XOR -> 32'hFF00_EDCB
  - opcodes 0101 and 1100-1111 -> 32'hF0F0_1234
- Pipelined sweep: 50 random (A,B) pairs, all 16 opcodes applied on consecutive cycles -> each output matches a reference model delayed by one cycle. With RISCV_ALU_FLAGS_EN defined, alu_zero_o matches (alu_p_o == 0) on every cycle.
